mdu_ctrl: RTL and testbench

- Iterative multiply/divide sequencer in the EX stage. Owns the HI/LO registers and runs the ALU's missing mult/div class over multiple cycles.
- Executes MULT, MULTU, DIV and DIVU by shift-add or restoring division, then a sign-correction cycle.
- Holds the pipeline through a stall output and accepts MTHI/MTLO writes.
- The pipeline reads HI/LO directly for MFHI/MFLO.

---
 rtl/mdu_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide sequencer for the EX stage. Owns HI/LO and runs
// MULT/MULTU (shift-add) and DIV/DIVU (restoring) over WIDTH cycles, followed
// by one sign-correction cycle.
//
// Handshake: an operation is accepted in IDLE when start_i=1, at least one
// mdu_op_i bit is set, done_o=0 and flush_i=0. stall_o holds the pipeline
// while the operation is in flight and drops in the done_o cycle, so the
// held start_i retires exactly once.
module mdu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [3:0]       mdu_op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_lo_q, neg_lo_d;   // product sign / quotient sign
    logic                 neg_hi_q, neg_hi_d;   // remainder sign (divide only)
    logic                 div0_q, div0_d;
    logic [WIDTH-1:0]     src1_q, src1_d;       // raw dividend for divide-by-zero
    logic [WIDTH-1:0]     a_q, a_d;             // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   prod_q, prod_d;       // {partial sum, remaining multiplier}
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;         // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    // Operation decode: lowest set bit of mdu_op_i wins
    logic             op_valid;
    logic             op_div;
    logic             op_signed;
    logic             s1, s2;
    logic [WIDTH-1:0] mag1, mag2;
    logic             accept;

    // Decode the requested op and form operand magnitudes
    always_comb begin
        op_div    = 1'b0;
        op_signed = 1'b0;
        op_valid  = |mdu_op_i;
        if (mdu_op_i[0]) begin
            op_signed = 1'b1;
        end else if (mdu_op_i[1]) begin
            op_signed = 1'b0;
        end else if (mdu_op_i[2]) begin
            op_div    = 1'b1;
            op_signed = 1'b1;
        end else if (mdu_op_i[3]) begin
            op_div    = 1'b1;
        end
        s1     = op_signed & src1_i[WIDTH-1];
        s2     = op_signed & src2_i[WIDTH-1];
        mag1   = s1 ? (~src1_i + 1'b1) : src1_i;
        mag2   = s2 ? (~src2_i + 1'b1) : src2_i;
        accept = (state_q == IDLE) & start_i & op_valid & ~done_q & ~flush_i;
    end

    // One iteration of each datapath; only the active one is committed
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH+1:0] div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_ge    = (div_shift >= {2'b00, a_q});
        div_diff  = div_shift[WIDTH:0] - {1'b0, a_q};
    end

    // Sign-corrected results, consumed in FIX
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        prod_fix = neg_lo_q ? (~prod_q + 1'b1) : prod_q;
        quo_fix  = neg_lo_q ? (~quo_q + 1'b1) : quo_q;
        rem_fix  = neg_hi_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
    end

    // Next-state, datapath and HI/LO update logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        src1_d   = src1_q;
        a_d      = a_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = CALC;
                    cnt_d    = '0;
                    is_div_d = op_div;
                    neg_lo_d = s1 ^ s2;
                    neg_hi_d = op_div & s1;
                    div0_d   = op_div & (src2_i == '0);
                    src1_d   = src1_i;
                    if (op_div) begin
                        a_d    = mag2;
                        rem_d  = '0;
                        quo_d  = mag1;
                        prod_d = '0;
                    end else begin
                        a_d    = mag1;
                        prod_d = {{WIDTH{1'b0}}, mag2};
                        rem_d  = '0;
                        quo_d  = '0;
                    end
                end else if (!flush_i) begin
                    // Move-to writes only land when no operation starts
                    if (mthi_i) hi_d = src1_i;
                    if (mtlo_i) lo_d = src1_i;
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    if (is_div_q) begin
                        rem_d = div_ge ? div_diff : div_shift[WIDTH:0];
                        quo_d = {quo_q[WIDTH-2:0], div_ge};
                    end else begin
                        prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (!flush_i) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else if (div0_q) begin
                        hi_d = src1_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            src1_q   <= '0;
            a_q      <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
            src1_q   <= src1_d;
            a_q      <= a_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Output drive; a start with no op bit set does not stall the pipeline
    always_comb begin
        busy_o  = (state_q == CALC) | (state_q == FIX);
        done_o  = done_q;
        hi_o    = hi_q;
        lo_o    = lo_q;
        stall_o = busy_o | (start_i & op_valid & ~done_q) | ((mthi_i | mtlo_i) & busy_o);
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed corner cases plus random ops, with results
// predicted by plain integer arithmetic and checked by a done_o monitor.
module tb_mdu_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start_i;
  logic [3:0]   mdu_op_i;
  logic [W-1:0] src1_i;
  logic [W-1:0] src2_i;
  logic         mthi_i;
  logic         mtlo_i;
  logic         flush_i;
  logic         stall_o;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int tests;
  int fails;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0] model_hi;
  logic [W-1:0] model_lo;

  mdu_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start_i),
    .mdu_op_i (mdu_op_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .mthi_i   (mthi_i),
    .mtlo_i   (mtlo_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // reference model: {HI, LO} from integer arithmetic
  function automatic logic [2*W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    if (op[0]) begin
      p = 64'(sa * sb);
    end else if (op[1]) begin
      p = {32'h0, a} * {32'h0, b};
    end else if (op[2]) begin
      if (b == 0) p = {a, 32'hFFFF_FFFF};
      else begin
        q = sa / sb;
        r = sa % sb;
        p = {r[31:0], q[31:0]};
      end
    end else if (op[3]) begin
      if (b == 0) p = {a, 32'hFFFF_FFFF};
      else p = {a % b, a / b};
    end
    return p;
  endfunction

  // scoreboard monitor: every done_o pulse pops one expected result
  always @(negedge clk) begin
    if (!reset && done_o) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got hi=0x%08h lo=0x%08h expected no result", hi_o, lo_o);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        check("result_hi", hi_o, e[2*W-1:W]);
        check("result_lo", lo_o, e[W-1:0]);
      end
    end
  end

  // driver: kind 0 normal, 1 MTLO while busy at cycle 'at', 2 flush at 'at', 3 reset at 'at'
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int kind, input int at);
    logic [2*W-1:0] e;
    int n;
    logic fin;
    logic hold_ok;
    @(posedge clk); #1;
    start_i  = 1'b1;
    mdu_op_i = op;
    src1_i   = a;
    src2_i   = b;
    e = model(op, a, b);
    exp_q.push_back(e);
    n = 0;
    fin = 1'b0;
    hold_ok = 1'b1;
    @(negedge clk);
    check("stall_at_accept", {31'b0, stall_o}, 32'd1);
    while (!fin && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        src1_i = $urandom;
        src2_i = $urandom;
      end
      if (kind == 1 && n == at) begin
        mtlo_i = 1'b1;
        src1_i = $urandom;
      end
      if (kind == 1 && n == at + 1) mtlo_i = 1'b0;
      if (kind == 2 && n == at) begin
        start_i = 1'b0;
        flush_i = 1'b1;
      end
      if (kind == 2 && n == at + 1) flush_i = 1'b0;
      if (kind == 3 && n == at) begin
        start_i = 1'b0;
        reset   = 1'b1;
      end
      if (kind == 3 && n == at + 1) reset = 1'b0;
      @(negedge clk);
      if (kind == 1 && n == at) check("mt_busy_stall", {31'b0, stall_o}, 32'd1);
      if (kind == 1 && n == at + 1) check("mt_busy_lo_hold", lo_o, model_lo);
      if (kind == 2 && n == at + 1) begin
        check("flush_idle", {31'b0, busy_o}, 32'd0);
        void'(exp_q.pop_back());
        fin = 1'b1;
      end else if (kind == 3 && n == at + 1) begin
        check("reset_busy", {31'b0, busy_o}, 32'd0);
        check("reset_hi", hi_o, '0);
        check("reset_lo", lo_o, '0);
        void'(exp_q.pop_back());
        model_hi = '0;
        model_lo = '0;
        fin = 1'b1;
      end else if (done_o) begin
        check("latency", n, W + 2);
        check("stall_drop_at_done", {31'b0, stall_o}, 32'd0);
        model_hi = e[2*W-1:W];
        model_lo = e[W-1:0];
        fin = 1'b1;
      end else if (kind != 3 || n < at) begin
        if (busy_o !== 1'b1 || stall_o !== 1'b1) hold_ok = 1'b0;
      end
    end
    if (!fin) begin
      tests++;
      fails++;
      $display("FAIL timeout: got no completion after %0d cycles expected one", n);
    end
    check("busy_stall_hold", {31'b0, hold_ok}, 32'd1);
    if (kind <= 1) begin
      // start_i still held across the done edge; it must not be re-accepted
      @(posedge clk); #1;
      start_i = 1'b0;
      @(negedge clk);
      check("no_reaccept", {31'b0, busy_o}, 32'd0);
    end
    start_i = 1'b0;
  endtask

  task automatic mt_write(input logic to_hi, input logic [W-1:0] v);
    @(posedge clk); #1;
    mthi_i = to_hi;
    mtlo_i = ~to_hi;
    src1_i = v;
    @(posedge clk); #1;
    mthi_i = 1'b0;
    mtlo_i = 1'b0;
    @(negedge clk);
    if (to_hi) begin
      model_hi = v;
      check("mthi", hi_o, v);
    end else begin
      model_lo = v;
      check("mtlo", lo_o, v);
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return W'($urandom_range(0, 10));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    model_hi = '0;
    model_lo = '0;
    reset    = 1'b1;
    start_i  = 1'b0;
    mdu_op_i = 4'b0;
    src1_i   = '0;
    src2_i   = '0;
    mthi_i   = 1'b0;
    mtlo_i   = 1'b0;
    flush_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_hi0", hi_o, '0);
    check("reset_lo0", lo_o, '0);
    check("reset_busy0", {31'b0, busy_o}, 32'd0);
    check("reset_done0", {31'b0, done_o}, 32'd0);
    check("reset_stall0", {31'b0, stall_o}, 32'd0);

    // start with no op bit: no stall, no accept
    @(posedge clk); #1;
    start_i = 1'b1;
    mdu_op_i = 4'b0000;
    src1_i = 32'd9;
    @(negedge clk);
    check("noop_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    check("noop_busy", {31'b0, busy_o}, 32'd0);

    // directed corner cases
    run_op(4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(4'b0001, 32'hFFFF_FFFD, 32'd7, 0, 0);
    run_op(4'b0100, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(4'b1000, 32'd7, 32'd2, 0, 0);
    run_op(4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(4'b1000, 32'd5, 32'd0, 0, 0);
    run_op(4'b0100, 32'hFFFF_FFF9, 32'd0, 0, 0);
    run_op(4'b1100, 32'hFFFF_FFF9, 32'd2, 0, 0);

    // flush mid-operation: no result, HI/LO keep prior values
    run_op(4'b0010, 32'd3, 32'd4, 2, 10);
    repeat (3) @(negedge clk);
    check("flush_keep_hi", hi_o, model_hi);
    check("flush_keep_lo", lo_o, model_lo);

    mt_write(1'b1, 32'h0000_1234);
    mt_write(1'b0, 32'hCAFE_0001);

    // MTLO during busy is held off
    run_op(4'b0001, 32'd1000, 32'hFFFF_FF00, 1, 5);

    // flush in IDLE blocks both accept and move-to writes
    @(posedge clk); #1;
    start_i = 1'b1;
    mdu_op_i = 4'b0001;
    flush_i = 1'b1;
    mthi_i = 1'b1;
    src1_i = 32'hABCD_0000;
    @(posedge clk); #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    mthi_i = 1'b0;
    @(negedge clk);
    check("idle_flush_busy", {31'b0, busy_o}, 32'd0);
    check("idle_flush_hi", hi_o, model_hi);

    // reset in the middle of an operation
    run_op(4'b1000, 32'd100, 32'd7, 3, 5);

    // random ops, multi-bit opcodes included
    for (int i = 0; i < 25; i++) begin
      run_op(4'($urandom_range(1, 15)), pick_operand(), pick_operand(), 0, 0);
    end

    repeat (4) @(negedge clk);
    check("queue_drain", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
